alu_mdu: RTL and testbench

Parametrised integer execution unit: a single-cycle ALU covering the existing 4-bit operation set, plus an iterative multiply/divide unit with HI/LO registers and a valid/ready handshake. It sits in the EX stage between the register-file read ports and the writeback mux. Decode stalls issue on `in_ready` while a multiply or divide is in flight.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mdu_iter.sv | 122 ++++++++++++
 rtl/alu_mdu.sv | 201 ++++++++++++++++++++
 tb/tb_alu_mdu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state type and widths for the alu_mdu execution unit.
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OP_W-1:0] OP_ADD   = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB   = 5'h02;
    localparam logic [OP_W-1:0] OP_AND   = 5'h03;
    localparam logic [OP_W-1:0] OP_OR    = 5'h04;
    localparam logic [OP_W-1:0] OP_NOR   = 5'h05;
    localparam logic [OP_W-1:0] OP_SLT   = 5'h06;
    localparam logic [OP_W-1:0] OP_SLL   = 5'h07;
    localparam logic [OP_W-1:0] OP_SRL   = 5'h08;
    localparam logic [OP_W-1:0] OP_SRA   = 5'h09;
    localparam logic [OP_W-1:0] OP_ADDU  = 5'h0A;
    localparam logic [OP_W-1:0] OP_SUBU  = 5'h0B;
    localparam logic [OP_W-1:0] OP_BGTZ  = 5'h0C;
    localparam logic [OP_W-1:0] OP_BGEZ  = 5'h0D;
    localparam logic [OP_W-1:0] OP_BNE   = 5'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 5'h0F;
    localparam logic [OP_W-1:0] OP_MULT  = 5'h10;
    localparam logic [OP_W-1:0] OP_MULTU = 5'h11;
    localparam logic [OP_W-1:0] OP_DIV   = 5'h12;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'h13;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'h14;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'h15;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'h16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle on a shared
// 2*WIDTH accumulator. Operands are converted to magnitudes on start; signs are re-applied on the outputs.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               div_q, div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_trial = acc_q[2*WIDTH-1:WIDTH-1];
        sub_diff  = rem_trial - {1'b0, opnd_q};

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        count_d  = count_q;
        busy_d   = busy_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;

        if (start) begin
            count_d = '1;
            div_d   = is_div;
            opnd_d  = b_mag;
            // A zero divisor finishes immediately with the raw dividend in the upper half.
            if (is_div && (b == '0)) begin
                busy_d   = 1'b0;
                acc_d    = {a, {WIDTH{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
            end else begin
                busy_d   = 1'b1;
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
            end
        end else if (busy_q) begin
            if (div_q) begin
                if (!sub_diff[WIDTH]) begin
                    acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};
            end
            count_d = count_q - CNT_W'(1);
            if (count_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign done = busy_q && (count_q == '0);

    // Quotient follows the XOR of the operand signs, remainder follows the dividend.
    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        if (div_q) begin
            res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage integer unit: single-cycle ALU plus optional iterative multiply/divide with HI/LO.
// Define ALU_MDU_EN to build the multiply/divide unit; otherwise its op-codes are illegal.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero, alu_ovf, alu_illegal;
    logic             is_mdu;

`ifdef ALU_MDU_EN
    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             mdu_start, is_div_op, mdu_signed;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign is_mdu     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    assign mdu_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_ready   = (state_q == IDLE);
    assign hi         = hi_q;
    assign lo         = lo_q;

    alu_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (mdu_start),
        .is_div   (is_div_op),
        .is_signed(mdu_signed),
        .a        (rs),
        .b        (rt),
        .done     (iter_done),
        .res_hi   (iter_hi),
        .res_lo   (iter_lo)
    );
`else
    assign is_mdu   = 1'b0;
    assign in_ready = 1'b1;
    assign hi       = '0;
    assign lo       = '0;
`endif

    always_comb begin
        sum         = rs + rt;
        diff        = rs - rt;
        alu_result  = '0;
        alu_zero    = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_zero   = (diff == '0);
                alu_ovf    = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_AND:  alu_result = rs & rt;
            OP_OR:   alu_result = rs | rt;
            OP_NOR:  alu_result = ~(rs | rt);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (rs < rt)};
            OP_SLL:  alu_result = rt << shamt;
            OP_SRL:  alu_result = rt >> shamt;
            OP_SRA:  alu_result = $signed(rt) >>> shamt;
            OP_ADDU: alu_result = sum;
            OP_SUBU: begin
                alu_result = diff;
                alu_zero   = (diff == '0);
            end
            OP_BGTZ: alu_zero = !rs[WIDTH-1] && (rs != '0);
            OP_BGEZ: alu_zero = !rs[WIDTH-1];
            OP_BNE:  alu_zero = (rs != rt);
            OP_LUI:  alu_result = rt << (WIDTH / 2);
`ifdef ALU_MDU_EN
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ;
            OP_MFHI: alu_result = hi_q;
            OP_MFLO: alu_result = lo_q;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    // Result flags hold between completions; only out_valid is a pulse.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;

        if (in_valid && in_ready && !is_mdu) begin
            out_valid_d = 1'b1;
            result_d    = alu_result;
            zero_d      = alu_zero;
            overflow_d  = alu_ovf;
            illegal_d   = alu_illegal;
        end

`ifdef ALU_MDU_EN
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mdu_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && is_mdu) begin
                    mdu_start = 1'b1;
                    state_d   = (is_div_op && (rt == '0)) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (iter_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                result_d    = iter_lo;
                zero_d      = 1'b0;
                overflow_d  = 1'b0;
                illegal_d   = 1'b0;
                hi_d        = iter_hi;
                lo_d        = iter_lo;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

`ifdef ALU_MDU_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: the driver pushes model predictions, a monitor pops them on out_valid.
// The reference model follows ALU_MDU_EN the same way the design does.
module tb_alu_mdu;

    localparam int W = 32;
`ifdef ALU_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic         clock    = 1'b0;
    logic         reset_n  = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op       = '0;
    logic [W-1:0] rs       = '0;
    logic [W-1:0] rt       = '0;
    logic [4:0]   shamt    = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         overflow;
        logic         illegal;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycle;
    } exp_t;

    exp_t         exp_q[$];
    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           cycle_cnt    = 0;
    int           busy_from    = 0;
    int           busy_until   = 0;
    logic [W-1:0] m_hi         = '0;
    logic [W-1:0] m_lo         = '0;
    logic [W-1:0] last_result  = '0;
    logic         last_zero    = 1'b0;

    alu_mdu #(
        .WIDTH  (W),
        .SHAMT_W(5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .shamt    (shamt),
        .out_valid(out_valid),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle_cnt, act, expv);
        end
    endtask

    // Reference model: true-value arithmetic on 64-bit integers; cycle field carries the latency.
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [4:0] s);
        exp_t        e;
        longint      sa, sb, wide;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.result = '0; e.zero = 1'b0; e.overflow = 1'b0; e.illegal = 1'b0; e.cycle = 0;
        case (o)
            5'h00: ;
            5'h01: begin
                e.result = a + b; wide = sa + sb;
                e.overflow = (wide != longint'($signed(e.result)));
            end
            5'h02: begin
                e.result = a - b; wide = sa - sb; e.zero = (a == b);
                e.overflow = (wide != longint'($signed(e.result)));
            end
            5'h03: e.result = a & b;
            5'h04: e.result = a | b;
            5'h05: e.result = ~(a | b);
            5'h06: e.result = (sa < sb) ? 32'd1 : 32'd0;
            5'h07: e.result = b << s;
            5'h08: e.result = b >> s;
            5'h09: e.result = 32'(sb >>> s);
            5'h0A: e.result = a + b;
            5'h0B: begin e.result = a - b; e.zero = (a == b); end
            5'h0C: e.zero = (sa > 0);
            5'h0D: e.zero = (sa >= 0);
            5'h0E: e.zero = (a != b);
            5'h0F: e.result = b * 32'd65536;
            5'h10, 5'h11, 5'h12, 5'h13: begin
                if (MDU_EN) begin
                    e.cycle = W + 1;
                    if (o == 5'h10) begin
                        p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0];
                    end else if (o == 5'h11) begin
                        p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0];
                    end else if (b == '0) begin
                        m_hi = a; m_lo = '1; e.cycle = 1;
                    end else if (o == 5'h12) begin
                        m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
                    end else begin
                        m_lo = a / b; m_hi = a % b;
                    end
                    e.result = m_lo;
                end else begin
                    e.illegal = 1'b1;
                end
            end
            5'h14: if (MDU_EN) e.result = m_hi; else e.illegal = 1'b1;
            5'h15: if (MDU_EN) e.result = m_lo; else e.illegal = 1'b1;
            5'h16: e.result = (a < b) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] s);
        exp_t e;
        int   waited;
        int   n;
        op = o; rs = a; rt = b; shamt = s; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        n = cycle_cnt + 1;
        e = model(o, a, b, s);
        if (e.cycle > 0) begin
            busy_from  = n;
            busy_until = n + e.cycle;
        end
        e.cycle = e.cycle + n;
        exp_q.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_result"}, result, 32'd0);
        checkOutput({tag, "_zero"}, 32'(zero), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
        checkOutput({tag, "_hi"}, hi, 32'd0);
        checkOutput({tag, "_lo"}, lo, 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: samples 2 time units after each rising edge.
    always @(posedge clock) begin
        exp_t e;
        #2;
        checkOutput("in_ready", 32'(in_ready),
                    (cycle_cnt >= busy_from && cycle_cnt < busy_until) ? 32'd0 : 32'd1);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("latency", 32'(cycle_cnt), 32'(e.cycle));
                checkOutput("result", result, e.result);
                checkOutput("zero", 32'(zero), 32'(e.zero));
                checkOutput("overflow", 32'(overflow), 32'(e.overflow));
                checkOutput("illegal", 32'(illegal), 32'(e.illegal));
                checkOutput("hi", hi, e.hi);
                checkOutput("lo", lo, e.lo);
                last_result = e.result;
                last_zero   = e.zero;
            end
        end else begin
            checkOutput("result_hold", result, last_result);
            checkOutput("zero_hold", 32'(zero), 32'(last_zero));
            if (exp_q.size() > 0 && cycle_cnt > exp_q[0].cycle) begin
                checkOutput("out_valid_missing", 32'(out_valid), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        logic [4:0] o;
        $display("[TB] starting, MDU_EN=%0d", MDU_EN);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkResetState("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases from the boundary list.
        applyStimulus(5'h01, 32'h7FFF_FFFF, 32'h1, 5'd0);
        applyStimulus(5'h0A, 32'h7FFF_FFFF, 32'h1, 5'd0);
        applyStimulus(5'h02, 32'd5, 32'd5, 5'd0);
        applyStimulus(5'h0E, 32'd5, 32'd6, 5'd0);
        applyStimulus(5'h0D, 32'hFFFF_FFFF, 32'd0, 5'd0);
        applyStimulus(5'h0C, 32'd1, 32'd0, 5'd0);
        applyStimulus(5'h10, 32'hFFFF_FFFD, 32'd7, 5'd0);
        applyStimulus(5'h14, 32'd0, 32'd0, 5'd0);
        applyStimulus(5'h15, 32'd0, 32'd0, 5'd0);
        applyStimulus(5'h12, 32'hFFFF_FFF9, 32'd2, 5'd0);
        applyStimulus(5'h13, 32'd7, 32'd0, 5'd0);
        applyStimulus(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        applyStimulus(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        applyStimulus(5'h03, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        applyStimulus(5'h04, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        applyStimulus(5'h07, 32'd0, 32'h0000_1234, 5'd4);
        applyStimulus(5'h1F, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
        applyStimulus(5'h16, 32'd1, 32'hFFFF_FFFF, 5'd0);
        applyStimulus(5'h06, 32'd1, 32'hFFFF_FFFF, 5'd0);
        applyStimulus(5'h09, 32'd0, 32'h8000_0000, 5'd31);
        applyStimulus(5'h0F, 32'd0, 32'h0000_ABCD, 5'd0);

        // Abort a multiply with reset during its busy phase.
        applyStimulus(5'h10, 32'hFFFF_FFFD, 32'd7, 5'd0);
        repeat (9) @(negedge clock);
        reset_n     = 1'b0;
        exp_q.delete();
        m_hi        = '0;
        m_lo        = '0;
        busy_from   = 0;
        busy_until  = 0;
        last_result = '0;
        last_zero   = 1'b0;
        @(negedge clock);
        checkResetState("abort");
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("ready_after_abort", 32'(in_ready), 32'd1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) o = 5'($urandom_range(23, 31));
            else                           o = 5'($urandom_range(0, 22));
            applyStimulus(o, pick(), pick(), 5'($urandom_range(0, 31)));
        end

        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (exp_q.size() > 0) checkOutput("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
